// File: rtl/adder_pkg.sv
// adder_pkg: shared FSM state type and default operand width for the bit-serial adder
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int ADDER_WIDTH = 8;

endpackage

// File: rtl/full_adder_cell.sv
// full_adder_cell: combinational one-bit full adder built from two half adders
module full_adder_cell (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic Sum,
    output logic Cout
);

    logic p;
    logic c1;
    logic c2;

    assign p    = A ^ B;
    assign c1   = A & B;
    assign Sum  = p ^ Cin;
    assign c2   = p & Cin;
    assign Cout = c1 | c2;

endmodule

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: reuses one full-adder cell over WIDTH cycles, LSB first, to add A+B+Cin
module serial_adder_ctrl
    import adder_pkg::*;
#(
    parameter int WIDTH = ADDER_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout
);

    localparam int CW = $clog2(WIDTH);

    state_t           state;
    state_t           nxt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             s;
    logic             c_out;
    logic             last;
    logic             ld;

    full_adder_cell u_cell (
        .A   (a_sh[0]),
        .B   (b_sh[0]),
        .Cin (carry),
        .Sum (s),
        .Cout(c_out)
    );

    assign busy = (state == RUN);
    assign last = (cnt == CW'(WIDTH - 1));
    assign ld   = start && (state != RUN);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt;
    end

    // Next state: DONE accepts a new start directly for back-to-back additions
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = start ? RUN : IDLE;
            RUN:     nxt = last ? DONE : RUN;
            DONE:    nxt = start ? RUN : IDLE;
            default: nxt = IDLE;
        endcase
    end

    // Datapath: operand capture, one bit per RUN cycle, results published only from DONE
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sh  <= '0;
            b_sh  <= '0;
            res   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            done  <= 1'b0;
            Sum   <= '0;
            Cout  <= 1'b0;
        end else begin
            if (ld) begin
                a_sh  <= A;
                b_sh  <= B;
                carry <= Cin;
                cnt   <= '0;
            end else if (state == RUN) begin
                a_sh  <= a_sh >> 1;
                b_sh  <= b_sh >> 1;
                carry <= c_out;
                cnt   <= cnt + 1'b1;
                res   <= {s, res[WIDTH-1:1]};
            end
            done <= (state == DONE);
            if (state == DONE) begin
                Sum  <= res;
                Cout <= carry;
            end
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: directed vectors for the bit-serial adder with hand-computed results
module tb_serial_adder_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] A = '0;
    logic [7:0] B = '0;
    logic       Cin = 1'b0;
    logic       busy;
    logic       done;
    logic [7:0] Sum;
    logic       Cout;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int ndone = 0;
    int t0 = 0;

    serial_adder_ctrl #(.WIDTH(8)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .A    (A),
        .B    (B),
        .Cin  (Cin),
        .busy (busy),
        .done (done),
        .Sum  (Sum),
        .Cout (Cout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) if (done) ndone <= ndone + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // present operands at a negedge; returns #1 after the accepting edge
    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic c);
        @(negedge clk);
        A = a;
        B = b;
        Cin = c;
        start = 1'b1;
        @(posedge clk);
        t0 = cyc + 1;
        #1 start = 1'b0;
    endtask

    // wait for done, then check latency, pulse width and result
    task automatic finish_op(input string tag, input logic [7:0] es, input logic ec, output int nb);
        int n = 0;
        nb = busy && !done;
        do begin
            @(posedge clk);
            #1 n++;
            if (busy && !done) nb++;
        end while (!done && n < 20);
        chk({tag, "_done"}, done, 1'b1);
        chk({tag, "_lat"}, cyc - t0, 9);
        chk({tag, "_sum"}, Sum, es);
        chk({tag, "_cout"}, Cout, ec);
    endtask

    task automatic check_pulse_end(input string tag);
        @(posedge clk);
        #1 chk({tag, "_width"}, done, 1'b0);
    endtask

    initial begin
        int nb;
        int d0;
        logic [8:0] ref_sum;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sum", Sum, 0);
        chk("rst_cout", Cout, 0);
        @(negedge clk) rst_n = 1'b1;

        issue(8'h00, 8'h00, 1'b0);
        finish_op("zero", 8'h00, 1'b0, nb);
        chk("zero_busy_cycles", nb, 8);
        check_pulse_end("zero");

        issue(8'hFF, 8'h01, 1'b0);
        repeat (8) @(posedge clk);
        #1;
        chk("b2b_done_state_busy", busy, 0);
        A = 8'h3C;
        B = 8'h42;
        Cin = 1'b0;
        start = 1'b1;
        @(posedge clk);
        t0 = cyc + 1;
        #1 start = 1'b0;
        chk("ovf_done", done, 1);
        chk("ovf_sum", Sum, 8'h00);
        chk("ovf_cout", Cout, 1);
        chk("b2b_no_gap", busy, 1);
        finish_op("b2b", 8'h7E, 1'b0, nb);
        check_pulse_end("b2b");

        issue(8'hA5, 8'h5A, 1'b1);
        finish_op("cin_chain", 8'h00, 1'b1, nb);
        check_pulse_end("cin_chain");

        d0 = ndone;
        issue(8'h10, 8'h20, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        A = 8'hFF;
        B = 8'hFF;
        Cin = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        finish_op("busy_start", 8'h30, 1'b0, nb);
        check_pulse_end("busy_start");
        repeat (12) @(posedge clk);
        #1;
        chk("busy_start_pulses", ndone - d0, 1);
        chk("busy_start_idle", busy, 0);

        issue(8'h80, 8'h80, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b0;
        d0 = ndone;
        @(posedge clk);
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_sum", Sum, 0);
        chk("midrst_cout", Cout, 0);
        chk("midrst_done", done, 0);
        @(negedge clk) rst_n = 1'b1;
        repeat (12) @(posedge clk);
        #1 chk("midrst_no_done", ndone - d0, 0);
        issue(8'h01, 8'h02, 1'b0);
        finish_op("after_rst", 8'h03, 1'b0, nb);

        for (int i = 0; i < 8; i++) begin
            logic a;
            logic b;
            logic c;
            {a, b, c} = 3'(i);
            ref_sum = {8'h00, a} + {8'h00, b} + {8'h00, c};
            issue({7'b0, a}, {7'b0, b}, c);
            finish_op($sformatf("cell_lsb%0d", i), ref_sum[7:0], ref_sum[8], nb);
            ref_sum = {1'b0, {8{a}}} + {1'b0, {8{b}}} + {8'h00, c};
            issue({8{a}}, {8{b}}, c);
            finish_op($sformatf("cell_all%0d", i), ref_sum[7:0], ref_sum[8], nb);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
